pindex_sram_arb: RTL

Arbiter and write-buffer for the single-port pooling-index SRAM shared by an encoder block and its mirrored decoder block. The encoder stores max-pool position indices, and the decoder reads them back for unpooling. The decoder read stream cannot be stalled, so reads always win the SRAM port. Encoder writes are queued in a small FIFO with ready/valid back-pressure, and reads that hit a still-queued write are forwarded from the FIFO.

---
 rtl/bcedn_pkg.sv | 26 ++
 rtl/pindex_wr_fifo.sv | 84 ++++++++
 rtl/pindex_sram_arb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bcedn_pkg.sv
// Shared definitions for the encoder/decoder pooling-index path.
// Index width helper, default word type and the SRAM read latency.
package bcedn_pkg;

  localparam int unsigned PINDEX_RD_LATENCY = 2;

  localparam int unsigned DEF_PINDEX_WIDTH = 2;
  localparam int unsigned DEF_N_PE         = 1;

  typedef logic [DEF_PINDEX_WIDTH*DEF_N_PE-1:0] pindex_word_t;

  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_READ  = 2'd1,
    PORT_WRITE = 2'd2
  } port_op_t;

  // Bits needed to name one position inside a pool window, never less than 1.
  function automatic int unsigned pindex_width(input int unsigned pool_h,
                                               input int unsigned pool_w);
    int unsigned w;
    w = $clog2(pool_h * pool_w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pindex_wr_fifo.sv
// Write buffer for the pooling-index SRAM: circular queue of (addr, data)
// entries plus a parallel address compare returning the newest match.
module pindex_wr_fifo #(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  output logic                  cmp_hit,
  output logic [DATA_WIDTH-1:0] cmp_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_addr = addr_q[head];
  assign head_data = data_q[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        addr_q[tail] <= push_addr;
        data_q[tail] <= push_data;
        tail         <= tail + PTR_W'(1);
      end
      if (do_pop) begin
        head <= head + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to newest so the last match left standing is the newest write.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    cmp_hit  = 1'b0;
    cmp_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_q[idx] == cmp_addr)) begin
        cmp_hit  = 1'b1;
        cmp_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/pindex_sram_arb.sv
// Single-port pooling-index SRAM arbiter: decoder reads always win the port,
// encoder writes queue in a FIFO and are forwarded to reads that hit them.
module pindex_sram_arb
  import bcedn_pkg::*;
#(
  parameter int unsigned PINDEX_WIDTH = pindex_width(2, 2),
  parameter int unsigned N_PE         = 1,
  parameter int unsigned DATA_WIDTH   = PINDEX_WIDTH * N_PE,
  parameter int unsigned ADDR_WIDTH   = 19,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  wr_idle
);

  localparam int unsigned LAT = PINDEX_RD_LATENCY;

  port_op_t              port_op;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  logic [LAT-1:0]        vld_pipe;
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;

  pindex_wr_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .cmp_addr  (rd_addr),
    .cmp_hit   (fwd_hit),
    .cmp_data  (fwd_data)
  );

  assign wr_ready = ~fifo_full;
  assign wr_idle  = fifo_empty;
  assign push     = wr_req & wr_ready;
  assign pop      = (port_op == PORT_WRITE);

  always_comb begin
    port_op = PORT_IDLE;
    if (rd_req) begin
      port_op = PORT_READ;
    end else if (!fifo_empty) begin
      port_op = PORT_WRITE;
    end
  end

  // Outputs are forced to zero while rst is high so no access escapes
  // during reset even though the port decode is purely combinational.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = head_addr;
    sram_wdata = head_data;
    case (port_op)
      PORT_READ: begin
        sram_en   = 1'b1;
        sram_addr = rd_addr;
      end
      PORT_WRITE: begin
        sram_en = 1'b1;
        sram_we = 1'b1;
      end
      default: begin
        sram_en = 1'b0;
      end
    endcase
    if (rst) begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
    end
  end

  // Forward data is captured from the FIFO state at the start of the read
  // cycle, so a write accepted alongside the read is not seen by it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      byp_hit  <= 1'b0;
      byp_data <= '0;
      rd_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-2:0], rd_req};
      if (rd_req) begin
        byp_hit  <= fwd_hit;
        byp_data <= fwd_data;
      end
      if (vld_pipe[LAT-2]) begin
        rd_data <= byp_hit ? byp_data : sram_rdata;
      end
    end
  end

  assign rd_valid = vld_pipe[LAT-1];

endmodule
